// File: rtl/fpu_op_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_scheduler_pkg
// Description : Shared op tags and FSM encodings for the FPU op scheduler.
// Revision    : 1.0  initial release
// ============================================================================
package fpu_op_scheduler_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_op_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_scheduler_if
// Description : Request/grant, result handshake and counter bundle of the scheduler.
// Revision    : 1.0  initial release
// ============================================================================
interface fpu_op_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             AddReq;
    logic             MulReq;
    logic             AddGnt;
    logic             MulGnt;
    logic             OpSel;
    logic             StgEn;
    logic             AlgorSel;
    logic             ResValid;
    logic             ResReady;
    logic             Drain;
    logic             Idle;
    logic [CNT_W-1:0] AddCnt;
    logic [CNT_W-1:0] MulCnt;
    logic [CNT_W-1:0] StallCnt;

    // Scheduler side
    modport master (
        input  AddReq, MulReq, ResReady, Drain,
        output AddGnt, MulGnt, OpSel, StgEn, AlgorSel, ResValid, Idle,
               AddCnt, MulCnt, StallCnt
    );

    // Requesters / result consumer side
    modport slave (
        output AddReq, MulReq, ResReady, Drain,
        input  AddGnt, MulGnt, OpSel, StgEn, AlgorSel, ResValid, Idle,
               AddCnt, MulCnt, StallCnt
    );
endinterface
`default_nettype wire

// File: rtl/fpu_sched_arb.sv
`default_nettype none
// ============================================================================
// Module      : fpu_sched_arb
// Description : Two-way round-robin arbiter (bit0 = ADD, bit1 = MUL).
// Revision    : 1.0  initial release
// ============================================================================
module fpu_sched_arb
    import fpu_op_scheduler_pkg::*;
(
    input  wire logic       Clk,
    input  wire logic       Rst_n,
    input  wire logic [1:0] Req,
    input  wire logic       Enable,
    output logic      [1:0] Gnt,
    output logic            Winner
);

    logic r_lastGnt;

    // Contention goes to whichever side did not win last time
    always_comb begin
        Winner = OP_ADD;
        case (Req)
            2'b01:   Winner = OP_ADD;
            2'b10:   Winner = OP_MUL;
            2'b11:   Winner = ~r_lastGnt;
            default: Winner = OP_ADD;
        endcase
    end

    always_comb begin
        Gnt = 2'b00;
        if (Enable && (|Req)) begin
            Gnt = (Winner == OP_MUL) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_lastGnt <= OP_MUL;
        end else if (Enable && (|Req)) begin
            r_lastGnt <= Winner;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fpu_op_scheduler
// Description : Issue arbitration and op-tag pipeline for the shared ADD/MUL FPU.
//               FPU_SCHED_PERF_EN enables the saturating performance counters.
// Revision    : 1.0  initial release
// ============================================================================
module fpu_op_scheduler
    import fpu_op_scheduler_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16
) (
    input  wire logic           Clk,
    input  wire logic           Rst_n,
    fpu_op_scheduler_if.master  bus
);

    state_t                r_state;
    state_t                w_stateNext;
    logic [PIPE_DEPTH-1:0] r_valid;
    logic [PIPE_DEPTH-1:0] r_tag;
    wire  [PIPE_DEPTH-1:0] w_validNext;
    wire  [PIPE_DEPTH-1:0] w_tagNext;
    logic                  r_opSel;
    logic                  w_run;
    logic                  w_anyReq;
    logic                  w_advance;
    logic                  w_enable;
    logic                  w_winner;
    logic                  w_issue;
    logic                  w_issueOp;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;

    assign w_req     = {bus.MulReq, bus.AddReq};
    assign w_anyReq  = |w_req;
    assign w_advance = ~r_valid[PIPE_DEPTH-1] | bus.ResReady;

    // Drain takes effect in the cycle it is raised, so RUN only issues with Drain low
    always_comb begin
        w_stateNext = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.Drain) begin
                    w_stateNext = ST_DRAIN;
                end else begin
                    w_run = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bus.Drain) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: w_stateNext = ST_RUN;
        endcase
    end

    assign w_enable = w_advance & w_run & Rst_n;

    fpu_sched_arb u_arb (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Req    (w_req),
        .Enable (w_enable),
        .Gnt    (w_gnt),
        .Winner (w_winner)
    );

    assign w_issue   = |w_gnt;
    assign w_issueOp = w_gnt[1] ? OP_MUL : OP_ADD;

    // Bubbles enter stage 1 carrying the ADD tag
    generate
        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_validNext[k] = w_issue;
                assign w_tagNext[k]   = w_issueOp;
            end else begin : g_shift
                assign w_validNext[k] = r_valid[k-1];
                assign w_tagNext[k]   = r_tag[k-1];
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_RUN;
            r_valid <= '0;
            r_tag   <= '0;
            r_opSel <= OP_ADD;
        end else begin
            r_state <= w_stateNext;
            if (w_advance) begin
                r_valid <= w_validNext;
                r_tag   <= w_tagNext;
            end
            if (w_anyReq) begin
                r_opSel <= w_winner;
            end
        end
    end

    assign bus.AddGnt   = w_gnt[0];
    assign bus.MulGnt   = w_gnt[1];
    assign bus.OpSel    = Rst_n & (w_anyReq ? w_winner : r_opSel);
    assign bus.StgEn    = w_advance;
    assign bus.AlgorSel = r_tag[PIPE_DEPTH-1];
    assign bus.ResValid = r_valid[PIPE_DEPTH-1];
    assign bus.Idle     = ~(|r_valid) & ((r_state == ST_DRAIN) | ~w_anyReq | ~Rst_n);

`ifdef FPU_SCHED_PERF_EN
    localparam logic [CNT_W-1:0] c_cntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_addCnt;
    logic [CNT_W-1:0] r_mulCnt;
    logic [CNT_W-1:0] r_stallCnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_addCnt   <= '0;
            r_mulCnt   <= '0;
            r_stallCnt <= '0;
        end else if (r_valid[PIPE_DEPTH-1]) begin
            if (bus.ResReady) begin
                if (r_tag[PIPE_DEPTH-1] == OP_MUL) begin
                    if (r_mulCnt != c_cntMax) r_mulCnt <= r_mulCnt + 1'b1;
                end else begin
                    if (r_addCnt != c_cntMax) r_addCnt <= r_addCnt + 1'b1;
                end
            end else if (r_stallCnt != c_cntMax) begin
                r_stallCnt <= r_stallCnt + 1'b1;
            end
        end
    end

    assign bus.AddCnt   = r_addCnt;
    assign bus.MulCnt   = r_mulCnt;
    assign bus.StallCnt = r_stallCnt;
`else
    assign bus.AddCnt   = {CNT_W{1'b0}};
    assign bus.MulCnt   = {CNT_W{1'b0}};
    assign bus.StallCnt = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_op_scheduler
// Description : Self-checking bench for fpu_op_scheduler: queue model plus directed cases.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fpu_op_scheduler;

    localparam int D  = 3;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_op_scheduler_if #(.CNT_W(CW)) ifc ();

    fpu_op_scheduler #(.PIPE_DEPTH(D), .CNT_W(CW)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (ifc)
    );

`ifdef FPU_SCHED_PERF_EN
    fpu_op_scheduler_if #(.CNT_W(2)) ifcS ();
    assign ifcS.AddReq   = ifc.AddReq;
    assign ifcS.MulReq   = ifc.MulReq;
    assign ifcS.ResReady = ifc.ResReady;
    assign ifcS.Drain    = ifc.Drain;

    fpu_op_scheduler #(.PIPE_DEPTH(D), .CNT_W(2)) dutS (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (ifcS)
    );
`endif

    int nPass  = 0;
    int nTotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model: queue of in-flight slots, newest at [0]; -1 = bubble, 0 = ADD, 1 = MUL
    int mPipe[$];
    bit mDrain, mLast, mOpSel;
    int mAdd, mMul, mStall;
    bit anyReq, adv, win, iss, lastV, empty;
    int lastT;
    int eA, eM, eS;

    function automatic void mReset();
        mPipe.delete();
        for (int i = 0; i < D; i++) mPipe.push_back(-1);
        mDrain = 0; mLast = 1; mOpSel = 0;
        mAdd = 0; mMul = 0; mStall = 0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mReset();
            chk("rst_AddGnt",   ifc.AddGnt,   0);
            chk("rst_MulGnt",   ifc.MulGnt,   0);
            chk("rst_OpSel",    ifc.OpSel,    0);
            chk("rst_StgEn",    ifc.StgEn,    1);
            chk("rst_AlgorSel", ifc.AlgorSel, 0);
            chk("rst_ResValid", ifc.ResValid, 0);
            chk("rst_Idle",     ifc.Idle,     1);
            chk("rst_AddCnt",   ifc.AddCnt,   0);
        end else begin
            anyReq = ifc.AddReq | ifc.MulReq;
            lastT  = mPipe[D-1];
            lastV  = (lastT >= 0);
            adv    = !lastV || ifc.ResReady;
            win    = (ifc.AddReq && ifc.MulReq) ? !mLast : ifc.MulReq;
            iss    = adv && !mDrain && !ifc.Drain && anyReq;
            empty  = 1;
            foreach (mPipe[i]) if (mPipe[i] >= 0) empty = 0;

            chk("AddGnt",   ifc.AddGnt,   iss && !win);
            chk("MulGnt",   ifc.MulGnt,   iss && win);
            chk("OpSel",    ifc.OpSel,    anyReq ? win : mOpSel);
            chk("StgEn",    ifc.StgEn,    adv);
            chk("ResValid", ifc.ResValid, lastV);
            if (lastV) chk("AlgorSel", ifc.AlgorSel, lastT);
            chk("Idle",     ifc.Idle,     empty && (mDrain || !anyReq));

`ifdef FPU_SCHED_PERF_EN
            eA = sat(mAdd, CW); eM = sat(mMul, CW); eS = sat(mStall, CW);
            chk("AddCnt_w2",   ifcS.AddCnt,   sat(mAdd, 2));
            chk("MulCnt_w2",   ifcS.MulCnt,   sat(mMul, 2));
            chk("StallCnt_w2", ifcS.StallCnt, sat(mStall, 2));
`else
            eA = 0; eM = 0; eS = 0;
`endif
            chk("AddCnt",   ifc.AddCnt,   eA);
            chk("MulCnt",   ifc.MulCnt,   eM);
            chk("StallCnt", ifc.StallCnt, eS);

            if (lastV && ifc.ResReady) begin
                if (lastT == 1) mMul++; else mAdd++;
            end
            if (lastV && !ifc.ResReady) mStall++;
            if (adv) begin
                void'(mPipe.pop_back());
                mPipe.push_front(iss ? int'(win) : -1);
            end
            if (iss) mLast = win;
            if (anyReq) mOpSel = win;
            if (!mDrain && ifc.Drain) mDrain = 1;
            else if (mDrain && !ifc.Drain) mDrain = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    int issued, acc, cyc;

    initial begin
        ifc.AddReq = 0; ifc.MulReq = 0; ifc.ResReady = 0; ifc.Drain = 0;
        step();
        #1;
        chk("t0_rst_ResValid", ifc.ResValid, 0);
        chk("t0_rst_Idle",     ifc.Idle,     1);
        step();
        rst_n = 1;

        // 1: single ADD, result three cycles later
        ifc.AddReq = 1; ifc.ResReady = 1;
        #1 chk("t1_AddGnt_c0", ifc.AddGnt, 1);
        step(); ifc.AddReq = 0;
        #1 chk("t1_ResValid_c1", ifc.ResValid, 0);
        step(); #1 chk("t1_ResValid_c2", ifc.ResValid, 0);
        step(); #1 chk("t1_ResValid_c3", ifc.ResValid, 1);
        chk("t1_AlgorSel_c3", ifc.AlgorSel, 0);

        // 2: both requesting -> MUL,ADD,MUL,... and results in the same order
        for (int i = 0; i < 9; i++) begin
            step();
            ifc.AddReq = (i < 6); ifc.MulReq = (i < 6);
            #1;
            if (i < 6) begin
                chk("t2_MulGnt", ifc.MulGnt, (i % 2) == 0);
                chk("t2_AddGnt", ifc.AddGnt, (i % 2) == 1);
            end
            if (i >= 3) begin
                chk("t2_ResValid", ifc.ResValid, 1);
                chk("t2_AlgorSel", ifc.AlgorSel, ((i - 3) % 2) == 0);
            end
        end

        // 3: full pipe stalled for 4 cycles, nothing lost or duplicated
        issued = 0; acc = 0; cyc = 0;
        while ((issued < 6 || acc < 6) && cyc < 60) begin
            step();
            ifc.AddReq   = (issued < 6);
            ifc.ResReady = !(cyc >= 3 && cyc < 7);
            #1;
            if (cyc >= 3 && cyc < 7) begin
                chk("t3_StgEn_stall",  ifc.StgEn,  0);
                chk("t3_AddGnt_stall", ifc.AddGnt, 0);
            end
            if (ifc.AddGnt) issued++;
            if (ifc.ResValid && ifc.ResReady) acc++;
            cyc++;
        end
        chk("t3_issued",   issued, 6);
        chk("t3_accepted", acc,    6);

        // 4: drain with three ops in flight
        ifc.AddReq = 0; ifc.ResReady = 1;
        for (int i = 0; i < 3; i++) begin
            step(); ifc.AddReq = 1;
            #1 chk("t4_fill_AddGnt", ifc.AddGnt, 1);
        end
        step(); ifc.Drain = 1;
        #1 chk("t4_d0_AddGnt", ifc.AddGnt, 0);
        chk("t4_d0_ResValid", ifc.ResValid, 1);
        step(); #1 chk("t4_d1_ResValid", ifc.ResValid, 1);
        step(); #1 chk("t4_d2_ResValid", ifc.ResValid, 1);
        step(); #1 chk("t4_d3_Idle", ifc.Idle, 1);
        chk("t4_d3_ResValid", ifc.ResValid, 0);
        step(); ifc.Drain = 0;
        #1 chk("t4_d4_AddGnt", ifc.AddGnt, 0);
        step(); #1 chk("t4_d5_AddGnt", ifc.AddGnt, 1);
        step(); ifc.AddReq = 0;

        // 5: asynchronous reset while the pipe is full and stalled
        for (int i = 0; i < 3; i++) begin
            step(); ifc.AddReq = 1; ifc.MulReq = 1; ifc.ResReady = 1;
        end
        step(); ifc.ResReady = 0;
        #1 rst_n = 0;
        #1;
        chk("t5_ResValid", ifc.ResValid, 0);
        chk("t5_AddGnt",   ifc.AddGnt,   0);
        chk("t5_MulGnt",   ifc.MulGnt,   0);
        chk("t5_StgEn",    ifc.StgEn,    1);
        chk("t5_Idle",     ifc.Idle,     1);
        chk("t5_OpSel",    ifc.OpSel,    0);
        step(); rst_n = 1;
        #1 chk("t5_first_AddGnt", ifc.AddGnt, 1);
        step(); #1 chk("t5_second_MulGnt", ifc.MulGnt, 1);
        step(); ifc.AddReq = 0; ifc.MulReq = 0; ifc.ResReady = 1;
        repeat (4) step();

        // 6: 4 ADD + 2 MUL with 5 stall cycles, counters checked afterwards
        rst_n = 0;
        step(); rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            ifc.AddReq = (i < 4); ifc.MulReq = (i >= 4); ifc.ResReady = 1;
            #1 chk("t6_grant", {ifc.MulGnt, ifc.AddGnt}, (i < 4) ? 1 : 2);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            ifc.AddReq = 0; ifc.MulReq = 0; ifc.ResReady = 0;
            #1 chk("t6_StgEn_stall", ifc.StgEn, 0);
        end
        step(); ifc.ResReady = 1;
        repeat (6) step();
`ifdef FPU_SCHED_PERF_EN
        chk("t6_AddCnt",      ifc.AddCnt,    4);
        chk("t6_MulCnt",      ifc.MulCnt,    2);
        chk("t6_StallCnt",    ifc.StallCnt,  5);
        chk("t6_AddCnt_w2",   ifcS.AddCnt,   3);
        chk("t6_StallCnt_w2", ifcS.StallCnt, 3);
`else
        chk("t6_AddCnt_off",   ifc.AddCnt,   0);
        chk("t6_StallCnt_off", ifc.StallCnt, 0);
`endif
        step(); ifc.AddReq = 1;
        step(); ifc.AddReq = 0;
        repeat (4) step();
`ifdef FPU_SCHED_PERF_EN
        chk("t6_AddCnt_5",    ifc.AddCnt,  5);
        chk("t6_AddCnt_w2_5", ifcS.AddCnt, 3);
`else
        chk("t6_AddCnt_off_5", ifc.AddCnt, 0);
`endif
        chk("t6_Idle_end", ifc.Idle, 1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire
